// File: rtl/elevator_motion_ctrl.sv
// elevator_motion_ctrl
// Motion controller for a four-floor car. Outstanding calls are latched,
// served in SCAN order (keep going while calls lie ahead, then reverse),
// and each call opens the door for a fixed number of cycles.
//
// Optional feature: define EVACUATION_MODE_EN to enable the evacuation
// command. Once evac is seen the car drops every call, finishes any
// transit in progress, heads straight down to floor 0 without stopping,
// opens the door once there and then parks in DONE with stop asserted
// until reset. Without the macro, evac is ignored and stop is always 0.
//
// The outputs are either taken straight from registers or decoded from
// the registered state.
module elevator_motion_ctrl #(
  parameter int unsigned TRAVEL_CYCLES = 100000000,  // cycles per one-floor transit, 2..2^28-1
  parameter int unsigned DOOR_CYCLES   = 50000000    // cycles the door stays open, 2..2^28-1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] call_req,
  input  logic       evac,
  output logic       turn,
  output logic       direction,
  output logic       stop,
  output logic [1:0] floor,
  output logic       door_open,
  output logic [3:0] pending
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2,
    DONE = 2'd3
  } state_t;

  // Terminal counts. A counter that reaches these has completed the full
  // number of cycles in MOVE or DOOR.
  localparam logic [27:0] TRAVEL_LAST = 28'(TRAVEL_CYCLES - 1);
  localparam logic [27:0] DOOR_LAST   = 28'(DOOR_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  floor_q, floor_d;
  logic        dir_q, dir_d;
  logic [3:0]  pending_q, pending_d;
  logic [27:0] cnt_q, cnt_d;
  logic [3:0]  door_mask;
  logic        evac_now;

  // True when any call is strictly above floor 'at'.
  function automatic logic calls_above(input logic [3:0] calls, input logic [1:0] at);
    logic any;
    any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > int'(at)) any = any | calls[i];
    end
    return any;
  endfunction

  // True when any call is strictly below floor 'at'.
  function automatic logic calls_below(input logic [3:0] calls, input logic [1:0] at);
    logic any;
    any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(at)) any = any | calls[i];
    end
    return any;
  endfunction

  // True when a call lies beyond 'at' in the given travel direction. The
  // car only commits to a transit when this holds, so the floor can never
  // be pushed past 3 or below 0.
  function automatic logic calls_ahead(input logic [3:0] calls, input logic [1:0] at,
                                       input logic up);
    return up ? calls_above(calls, at) : calls_below(calls, at);
  endfunction

`ifdef EVACUATION_MODE_EN
  logic evac_q, evac_d;

  // The evacuation request acts in the cycle it is first seen, and the
  // latch keeps it active from the following cycle until reset.
  assign evac_d   = evac_q | evac;
  assign evac_now = evac_q | evac;

  // Evacuation latch, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      evac_q <= 1'b0;
    end else begin
      evac_q <= evac_d;
    end
  end
`else
  logic unused_evac;

  // Without the evacuation feature the command input has no effect.
  assign evac_now    = 1'b0;
  assign unused_evac = evac;
`endif

  // State register plus the floor, direction, call and timer registers.
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so that every
    // register samples the values from before this edge.
    if (reset) begin
      state_q   <= IDLE;
      dir_q     <= 1'b1;
      pending_q <= 4'b0000;
      cnt_q     <= 28'd0;
      // NOTE: a reset that lands during a transit or while the door is
      // open abandons the motion but keeps the floor where the car really
      // is. From a resting state, and at power-up, floor restarts at 0.
      if (state_q == MOVE || state_q == DOOR) begin
        floor_q <= floor_q;
      end else begin
        floor_q <= 2'd0;
      end
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next state: SCAN decisions in IDLE, transit timing and arrival
  // decisions in MOVE, door timing in DOOR.
  always_comb begin
    // NOTE: every signal gets a default first so that no path through the
    // block leaves one unassigned, which would infer a latch.
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    cnt_d   = 28'd0;

    case (state_q)
      IDLE: begin
        if (evac_now) begin
          // Evacuation: head down, or open at once if already at floor 0.
          dir_d = 1'b0;
          if (floor_q == 2'd0) begin
            state_d = DOOR;
          end else begin
            state_d = MOVE;
          end
        end else if (pending_q[floor_q]) begin
          state_d = DOOR;
        end else if (pending_q != 4'b0000) begin
          // SCAN: keep the last direction while calls lie ahead, else reverse.
          state_d = MOVE;
          dir_d   = calls_ahead(pending_q, floor_q, dir_q) ? dir_q : ~dir_q;
        end
      end

      MOVE: begin
        if (cnt_q == TRAVEL_LAST) begin
          // Arrival: the floor changes here and the transit timer restarts.
          // A call for a floor the car is already passing waits until the
          // car actually arrives there; the car never reverses mid-transit.
          floor_d = dir_q ? (floor_q + 2'd1) : (floor_q - 2'd1);
          if (evac_now) begin
            // Evacuation skips every intermediate door.
            dir_d = 1'b0;
            if (floor_d == 2'd0) begin
              state_d = DOOR;
            end
          end else if (pending_q[floor_d]) begin
            state_d = DOOR;
          end else if (!calls_ahead(pending_q, floor_d, dir_q)) begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 28'd1;
        end
      end

      DOOR: begin
        if (cnt_q == DOOR_LAST) begin
          if (evac_now && floor_q == 2'd0) begin
            state_d = DONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 28'd1;
        end
      end

      DONE: begin
        state_d = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outstanding calls: latch new requests, drop the one being served.
  always_comb begin
    door_mask = 4'b0000;
    pending_d = pending_q;
    if (evac_now) begin
      pending_d = 4'b0000;
    end else begin
      // A press at the floor whose door is already open is already served.
      if (state_q == DOOR) begin
        door_mask[floor_q] = 1'b1;
      end
      pending_d = pending_q | (call_req & ~door_mask);
      // The call is consumed as the door opens; a press arriving in that
      // same cycle for that floor is dropped with it.
      if (state_d == DOOR && state_q != DOOR) begin
        pending_d[floor_d] = 1'b0;
      end
    end
  end

  // Output decode from the registered state.
  always_comb begin
    turn      = (state_q == MOVE);
    door_open = (state_q == DOOR);
`ifdef EVACUATION_MODE_EN
    stop      = (state_q == DONE);
`else
    stop      = 1'b0;
`endif
  end

  assign floor     = floor_q;
  assign direction = dir_q;
  assign pending   = pending_q;

endmodule
